load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between the pipeline and a byte-addressed data memory
// LSU_LB_SIGNEXT_EN: when defined, byte loads are sign-extended; otherwise zero-extended.
module load_store_unit #(
  parameter int          SIZE     = 32,
  parameter logic [31:0] SIZE_MEM = 32'h7FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic            req_byte,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [SIZE-1:0] mem_address,
  output logic [SIZE-1:0] mem_dato,
  output logic            mem_MemWrite,
  output logic            mem_MemRead,
  output logic            mem_is_byte,
  input  logic [SIZE-1:0] mem_datoLeido,
  output logic [15:0]     fault_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] MEM_LIMIT  = SIZE'(SIZE_MEM);
  localparam logic [SIZE-1:0] WORD_LIMIT = SIZE'(SIZE_MEM - 32'd4);

  state_t          state_q;
  logic            write_q;
  logic            byte_q;
  logic [SIZE-1:0] addr_q;
  logic [SIZE-1:0] wdata_q;
  logic [SIZE-1:0] resp_rdata_q;
  logic            resp_fault_q;
  logic [15:0]     fault_count_q;

  logic            accept;
  logic            req_fault;
  logic            in_access;
  logic [7:0]      rd_byte;
  logic [SIZE-1:0] load_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign in_access = (state_q == ACCESS);

  // The fault decision is needed on the accept edge, so it is taken from the values being latched.
  assign req_fault = (req_addr >= MEM_LIMIT) ||
                     (!req_byte && ((req_addr[1:0] != 2'b00) || (req_addr > WORD_LIMIT)));

  assign rd_byte = mem_datoLeido[7:0];
`ifdef LSU_LB_SIGNEXT_EN
  assign load_data = byte_q ? {{(SIZE-8){rd_byte[7]}}, rd_byte} : mem_datoLeido;
`else
  assign load_data = byte_q ? {{(SIZE-8){1'b0}}, rd_byte} : mem_datoLeido;
`endif

  // Strobes decode from the registered state, so async reset drops them at once.
  assign mem_MemWrite = in_access && write_q;
  assign mem_MemRead  = in_access && !write_q;
  assign mem_is_byte  = in_access && byte_q;
  assign mem_address  = in_access ? addr_q : '0;
  assign mem_dato     = !(in_access && write_q) ? '0 :
                        byte_q ? {wdata_q[7:0], {(SIZE-8){1'b0}}} : wdata_q;

  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign fault_count = fault_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      byte_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q      <= req_write;
            byte_q       <= req_byte;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            if (req_fault) begin
              state_q      <= RESP;
              resp_fault_q <= 1'b1;
              if (fault_count_q != 16'hFFFF) fault_count_q <= fault_count_q + 16'd1;
            end else begin
              state_q      <= ACCESS;
              resp_fault_q <= 1'b0;
            end
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          resp_rdata_q <= write_q ? '0 : load_data;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
